nand3_exerciser: RTL and testbench
==================================

// Module: nand3_exerciser
// PURPOSE
//  Upstream stimulus sequencer and downstream response checker for the 3-input CMOS NAND cell.
//  - On a start pulse it drives every {A,B,C} vector in order 000..111.
//  - After each vector it waits a settle window, samples F and compares it against ~(A&B&C).
//  - It accumulates a saturating error count and a per-vector fail map.
//  Sits between the bench/control logic and the switch-level gate under test.
// PARAMETERS
//  SETTLE_CYCLES  2  clock cycles F is allowed to settle before sampling; 0 is legal
//  CNT_W          8  width of err_cnt
//  PASSES         1  full 8-vector sweeps per run; must be >=1
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      1-cycle run request; honoured only in IDLE or DONE
//  A        out  1      gate input A = vec[2]
//  B        out  1      gate input B = vec[1]
//  C        out  1      gate input C = vec[0]
//  F        in   1      gate output under test
//  busy     out  1      high from the cycle after an accepted start until the run ends
//  done     out  1      high (level) once the run completes; cleared by the next accepted start
//  pass     out  1      done && err_cnt==0
//  err_cnt  out  CNT_W  mismatching samples; saturates at all-ones
//  err_vec  out  8      bit v set if vector v failed in any pass (sticky within a run)
// BEHAVIOUR
//  Reset (async, any state, including mid-run):
//  - state=IDLE; A=B=C=0; busy=done=pass=0; err_cnt=0; err_vec=0; vec=0; pass counter=0.
//  FSM:
//  - IDLE --start--> DRIVE. Clear err_cnt, err_vec, vec and pass counter; busy=1.
//  - DRIVE (1 cycle): {A,B,C}=vec registered. Next state is SETTLE, or SAMPLE if settle length is 0.
//  - SETTLE: holds for exactly SETTLE_CYCLES cycles, then SAMPLE. A,B,C stable throughout.
//  - SAMPLE (1 cycle): exp = ~(A&B&C).
//    - If F!=exp (an X/Z on F also counts as a mismatch): err_cnt++ (unless saturated) and err_vec[vec]=1.
//    - If vec!=7: vec++ then DRIVE.
//    - If vec==7 and pass counter<PASSES-1: vec wraps to 0, pass counter++, then DRIVE.
//    - Otherwise go to DONE.
//  - DONE: busy=0, done=1; pass is valid. A,B,C hold 111. start -> DRIVE, with the same clears as from IDLE.
//  Timing and rules:
//  - Cycles per vector = SETTLE_CYCLES+2.
//  - done rises (SETTLE_CYCLES+2)*8*PASSES cycles after the start-accept edge.
//  - start while busy is ignored; there is no abort other than rst_n.
//  - err_cnt/err_vec update registered on the SAMPLE edge and are visible the next cycle.
//  - The final sample's error update and done rise on the same edge.
// CONFIGURATION
//  F_SYNC_EN:
//  - Defined: F passes through a 2-flop synchronizer reset to 1 (the NAND's idle value).
//  - Effective settle becomes SETTLE_CYCLES+2, and the per-vector time grows by 2 cycles.
//  - Undefined: F is sampled directly in SAMPLE with no added latency.
// TESTING
//  1. Defaults with a correct NAND; pulse start.
//     -> A,B,C step 000..111 every 4 cycles.
//     -> done=1 32 cycles after accept; pass=1, err_cnt=0, err_vec=8'h00.
//  2. F stuck-at-1 -> done; err_cnt=1, err_vec=8'h80, pass=0.
//  3. F stuck-at-0 -> err_cnt=7, err_vec=8'h7F, pass=0.
//  4. CNT_W=2, PASSES=2, F stuck-at-0 (14 fails) -> err_cnt=2'b11 saturated, err_vec=8'h7F.
//  5. start pulsed mid-run -> ignored, run length unchanged.
//     start in DONE -> err_cnt/err_vec cleared, busy=1, new sweep begins at 000.
//  6. rst_n low during vector 4 SETTLE -> immediately A=B=C=0, busy=done=0, err_cnt=0.
//     Next start runs a full sweep from 000.

Source files
------------

// File: rtl/nand3_exerciser.sv
// Stimulus sequencer and response checker for a 3-input NAND cell under test.
// Define F_SYNC_EN to pass F through a 2-flop synchronizer before it is sampled.
module nand3_exerciser #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 8,
   parameter int PASSES        = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             A,
   output logic             B,
   output logic             C,
   input  logic             F,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [7:0]       err_vec
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   logic f_s;

`ifdef F_SYNC_EN
   localparam int SYNC_STAGES = 2;
   logic [1:0] f_sync_q, f_sync_d;

   always_comb f_sync_d = {f_sync_q[0], F};

   // Reset to 1, which is the NAND output while all inputs sit at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) f_sync_q <= 2'b11;
      else        f_sync_q <= f_sync_d;
   end

   assign f_s = f_sync_q[1];
`else
   localparam int SYNC_STAGES = 0;
   assign f_s = F;
`endif

   localparam int SETTLE_EFF = SETTLE_CYCLES + SYNC_STAGES;
   localparam int SW = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_EFF > 0) ? SETTLE_EFF - 1 : 0);
   localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

   state_t           state_q, state_d;
   logic [2:0]       vec_q, vec_d;
   logic [2:0]       abc_q, abc_d;
   logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
   logic [PW-1:0]    pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [7:0]       err_vec_q, err_vec_d;
   logic             exp_f;
   logic             mismatch;

   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      abc_d        = abc_q;
      settle_cnt_d = settle_cnt_q;
      pass_cnt_d   = pass_cnt_q;
      err_cnt_d    = err_cnt_q;
      err_vec_d    = err_vec_q;
      exp_f        = ~(abc_q[2] & abc_q[1] & abc_q[0]);
      // Case inequality so that an undriven or unknown F is treated as a failure.
      mismatch     = (f_s !== exp_f);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_DRIVE;
               vec_d      = 3'd0;
               pass_cnt_d = '0;
               err_cnt_d  = '0;
               err_vec_d  = '0;
            end
         end
         S_DRIVE: begin
            abc_d        = vec_q;
            settle_cnt_d = '0;
            state_d      = (SETTLE_EFF == 0) ? S_SAMPLE : S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
            else settle_cnt_d = settle_cnt_q + SW'(1);
         end
         S_SAMPLE: begin
            if (mismatch) begin
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
               err_vec_d[vec_q] = 1'b1;
            end
            if (vec_q != 3'd7) begin
               vec_d   = vec_q + 3'd1;
               state_d = S_DRIVE;
            end else if (pass_cnt_q != PASS_LAST) begin
               vec_d      = 3'd0;
               pass_cnt_d = pass_cnt_q + PW'(1);
               state_d    = S_DRIVE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         vec_q        <= 3'd0;
         abc_q        <= 3'd0;
         settle_cnt_q <= '0;
         pass_cnt_q   <= '0;
         err_cnt_q    <= '0;
         err_vec_q    <= '0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         abc_q        <= abc_d;
         settle_cnt_q <= settle_cnt_d;
         pass_cnt_q   <= pass_cnt_d;
         err_cnt_q    <= err_cnt_d;
         err_vec_q    <= err_vec_d;
      end
   end

   assign A       = abc_q[2];
   assign B       = abc_q[1];
   assign C       = abc_q[0];
   assign busy    = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
   assign done    = (state_q == S_DONE);
   assign pass    = done && (err_cnt_q == '0);
   assign err_cnt = err_cnt_q;
   assign err_vec = err_vec_q;

endmodule

// File: tb/tb_nand3_exerciser.sv
// Scoreboarded bench: two exerciser instances drive behavioural NAND cells with random fault maps.
module tb_nand3_exerciser;

`ifdef F_SYNC_EN
   localparam int SYNC_ADD = 2;
`else
   localparam int SYNC_ADD = 0;
`endif
   // Cycles per vector for each instance: drive + settle + sample
   localparam int W0 = 2 + SYNC_ADD + 2;
   localparam int W1 = 0 + SYNC_ADD + 2;

   typedef struct {
      logic [7:0] cnt;
      logic [7:0] vec;
      logic       pass;
      int         cycles;
   } exp_t;

   logic       clk, rst_n;
   logic       start0, start1;
   logic       a0, b0, c0, f0, busy0, done0, pass0;
   logic       a1, b1, c1, f1, busy1, done1, pass1;
   logic [7:0] err_cnt0, err_vec0, err_vec1;
   logic [1:0] err_cnt1;
   logic [7:0] flip0, flip1;

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;

   nand3_exerciser dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
      .A(a0), .B(b0), .C(c0), .F(f0),
      .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err_cnt0), .err_vec(err_vec0)
   );

   nand3_exerciser #(.SETTLE_CYCLES(0), .CNT_W(2), .PASSES(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .A(a1), .B(b1), .C(c1), .F(f1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err_cnt1), .err_vec(err_vec1)
   );

   // Behavioural gate: a correct NAND, with every vector set in the flip map answered wrongly.
   always_comb f0 = ~(a0 & b0 & c0) ^ flip0[{a0, b0, c0}];
   always_comb f1 = ~(a1 & b1 & c1) ^ flip1[{a1, b1, c1}];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic get_done(input int i);
      return (i == 0) ? done0 : done1;
   endfunction
   function automatic logic get_busy(input int i);
      return (i == 0) ? busy0 : busy1;
   endfunction
   function automatic logic get_pass(input int i);
      return (i == 0) ? pass0 : pass1;
   endfunction
   function automatic logic [7:0] get_cnt(input int i);
      return (i == 0) ? err_cnt0 : {6'b0, err_cnt1};
   endfunction
   function automatic logic [7:0] get_vec(input int i);
      return (i == 0) ? err_vec0 : err_vec1;
   endfunction

   // Reference model: every flipped vector fails once per pass, count saturates at the counter width.
   function automatic exp_t model(input int i, input logic [7:0] flip);
      exp_t e;
      int   passes = (i == 0) ? 1 : 2;
      int   maxc   = (i == 0) ? 255 : 3;
      int   n      = $countones(flip) * passes;
      e.cnt    = 8'((n > maxc) ? maxc : n);
      e.vec    = flip;
      e.pass   = (n == 0);
      e.cycles = 8 * passes * ((i == 0) ? W0 : W1);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic setStart(input int i, input logic v);
      if (i == 0) start0 = v;
      else        start1 = v;
   endtask

   // Monitor: counts busy cycles and, on each rising done, pops and compares the oldest expectation.
   initial begin
      int   busy_cycles[2];
      logic prev_done[2];
      exp_t e;
      busy_cycles = '{0, 0};
      prev_done   = '{1'b0, 1'b0};
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_cycles = '{0, 0};
            prev_done   = '{1'b0, 1'b0};
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (get_busy(i)) busy_cycles[i]++;
               if (get_done(i) && !prev_done[i]) begin
                  if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                     checks++;
                     errors++;
                     $display("[TB] FAIL unexpected_done: dut%0d done with no pending run", i);
                  end else begin
                     e = (i == 0) ? q0.pop_front() : q1.pop_front();
                     checkOutput($sformatf("err_cnt%0d", i), get_cnt(i), e.cnt);
                     checkOutput($sformatf("err_vec%0d", i), get_vec(i), e.vec);
                     checkOutput($sformatf("pass%0d", i), get_pass(i), e.pass);
                     checkOutput($sformatf("run_len%0d", i), busy_cycles[i], e.cycles);
                  end
                  busy_cycles[i] = 0;
               end
               prev_done[i] = get_done(i);
            end
         end
      end
   end

   // One run: load the fault map, queue the model's answer, pulse start and wait for done.
   task automatic applyStimulus(input int i, input logic [7:0] flip, input bit mid_start,
                                input bit check_abc);
      exp_t e;
      logic was_done;
      int   k;
      @(negedge clk);
      if (i == 0) flip0 = flip;
      else        flip1 = flip;
      e = model(i, flip);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
      was_done = get_done(i);
      setStart(i, 1'b1);
      @(posedge clk);
      #1;
      setStart(i, 1'b0);
      checkOutput("busy_after_start", get_busy(i), 1);
      if (was_done) begin
         checkOutput("restart_done_clr", get_done(i), 0);
         checkOutput("restart_cnt_clr", get_cnt(i), 0);
         checkOutput("restart_vec_clr", get_vec(i), 0);
      end
      k = 0;
      while (!get_done(i) && k < 2000) begin
         @(posedge clk);
         k++;
         #1;
         if (check_abc && k >= 2 && ((k - 2) % W0) == 0 && ((k - 2) / W0) < 8)
            checkOutput("abc_sweep", {29'b0, a0, b0, c0}, (k - 2) / W0);
         if (mid_start && k == 10) setStart(i, 1'b1);
         if (mid_start && k == 11) setStart(i, 1'b0);
      end
      if (!get_done(i)) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: dut%0d got no done after %0d cycles required", i, k);
      end
      @(negedge clk);
   endtask

   // Reset asserted while dut0 is settling vector 4; everything must clear at once.
   task automatic resetMidRun();
      int k;
      @(negedge clk);
      flip0 = 8'h0F;
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      for (k = 0; k < 4 * W0 + 2; k++) @(posedge clk);
      #1;
      checkOutput("pre_reset_cnt", err_cnt0, 4);
      checkOutput("pre_reset_busy", busy0, 1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_abc", {29'b0, a0, b0, c0}, 0);
      checkOutput("mid_reset_busy", busy0, 0);
      checkOutput("mid_reset_done", done0, 0);
      checkOutput("mid_reset_cnt", err_cnt0, 0);
      checkOutput("mid_reset_vec", err_vec0, 0);
      q0.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      flip0  = 8'h00;
      flip1  = 8'h00;
      #1;
      checkOutput("reset_abc0", {29'b0, a0, b0, c0}, 0);
      checkOutput("reset_abc1", {29'b0, a1, b1, c1}, 0);
      checkOutput("reset_busy0", busy0, 0);
      checkOutput("reset_done0", done0, 0);
      checkOutput("reset_pass0", pass0, 0);
      checkOutput("reset_cnt0", err_cnt0, 0);
      checkOutput("reset_vec0", err_vec0, 0);
      checkOutput("reset_done1", done1, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(0, 8'h00, 1'b0, 1'b1);
      applyStimulus(0, 8'h80, 1'b0, 1'b0);
      applyStimulus(0, 8'h7F, 1'b0, 1'b0);
      applyStimulus(1, 8'h7F, 1'b0, 1'b0);
      applyStimulus(1, 8'h00, 1'b0, 1'b0);
      applyStimulus(0, 8'($urandom), 1'b1, 1'b0);
      applyStimulus(1, 8'($urandom), 1'b1, 1'b0);
      for (int r = 0; r < 4; r++) begin
         applyStimulus(0, 8'($urandom), 1'b0, 1'b0);
         applyStimulus(1, 8'($urandom), 1'b0, 1'b0);
      end

      resetMidRun();
      applyStimulus(0, 8'($urandom), 1'b0, 1'b1);
      applyStimulus(1, 8'($urandom), 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      checkOutput("queue0_drained", q0.size(), 0);
      checkOutput("queue1_drained", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
